pool_readback_ctrl: RTL
=======================

Name: pool_readback_ctrl

Overview:
- Downstream drain stage for the accumulate/activate/pool cluster.
- Waits until all 16 pool lanes (conv mode) or the FC activation path (FC mode) report completion.
- Then reads the pooled SA data BRAM or the FC data BRAM sequentially, using the 1-cycle-latency BRAM read ports.
- Streams the bytes to the next-layer ifmap loader over a valid/ready interface, with full back-pressure support.

Parameters:
- DATA_WIDTH, 8, width of one activation byte.
- SA_ADDR_WIDTH, 14, SA data BRAM read address width.
- FC_ADDR_WIDTH, 10, FC data BRAM read address width.
- LANES, 16, number of pool_last lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that arms a readback; sampled only in IDLE.
- mode_fc_i  in  1  0 = conv/pool readback, 1 = FC readback; latched at start.
- pool_size_i  in  4  pooled map side length (1..15); latched at start.
- ch_i  in  6  channel count (1..63); latched at start.
- fc_len_i  in  FC_ADDR_WIDTH  FC output bytes (0..1023); latched at start.
- pool_last_i  in  LANES  per-lane pool-done pulses/levels.
- act_last_i  in  1  FC activation done.
- sa_rden_o  out  1  SA BRAM read enable.
- sa_rdptr_o  out  SA_ADDR_WIDTH  SA BRAM read address.
- sa_rdata_i  in  DATA_WIDTH  SA BRAM data; valid 1 cycle after sa_rden_o.
- fc_rden_o  out  1  FC BRAM read enable.
- fc_rdptr_o  out  FC_ADDR_WIDTH  FC BRAM read address.
- fc_rdata_i  in  DATA_WIDTH  FC BRAM data; valid 1 cycle after fc_rden_o.
- data_o  out  DATA_WIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  qualifies the final element of the stream.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the readback completes.

Behaviour:
- Reset: state=IDLE, lane mask=0, counters=0, FIFO empty.
  - All outputs 0: rden, rdptr, data_o, valid_o, last_o, busy_o, done_o.
  - Reset mid-operation aborts immediately. Any in-flight BRAM data is discarded.
- Total count N:
  - Conv mode: N = pool_size × pool_size × ch, computed in 14 bits (max 14175, no overflow).
  - FC mode: N = fc_len.
- FSM states: IDLE, WAIT, READ, DRAIN.
  - IDLE: on start_i → latch configuration, clear lane mask → WAIT. start_i in any other state is ignored.
  - WAIT, conv mode: sticky mask |= pool_last_i each cycle; go to READ when the mask is all ones. Bits may arrive in any cycles, including all lanes in the same cycle as entering WAIT+1.
  - WAIT, FC mode: go to READ on act_last_i=1.
  - WAIT, N=0: done_o pulses on the exit cycle, return to IDLE, and valid_o is never asserted.
  - READ: issue reads at addresses 0..N-1, one per cycle at most.
    - A read is issued only when FIFO occupancy + in-flight reads < 2 (credit check).
    - Only the rden/rdptr of the latched mode toggles; the other port stays 0.
    - After read N-1 is issued → DRAIN.
  - DRAIN: once the FIFO is empty and the last handshake is done → done_o=1 for one cycle, then IDLE.
- FIFO: 2-entry skid buffer.
  - The BRAM return is written one cycle after rden.
  - Head entry drives data_o/valid_o.
  - Simultaneous push and pop allowed; it never overflows because of the credit check.
- Handshake:
  - Transfer occurs when valid_o && ready_i.
  - data_o/valid_o/last_o hold stable while valid_o && !ready_i.
  - last_o = 1 only on element N-1.
- Throughput: 1 byte/cycle sustained while ready_i=1.
  - First valid_o occurs 2 cycles after entering READ (1 cycle issue, 1 cycle BRAM).
- ready_i low indefinitely: reads stall after 2 credits are consumed; no data is lost.
- done_o pulses in the cycle after the handshake of element N-1; busy_o falls in that same cycle.

Decomposition:
- Package acpo_rb_pkg:
  - state enum (IDLE, WAIT, READ, DRAIN).
  - width constants DATA_WIDTH, SA_ADDR_WIDTH, FC_ADDR_WIDTH, LANES.
  - localparam FIFO_DEPTH=2.
- Sub-module rb_skid_fifo: 2-entry FIFO with push/pop/full/empty/count. The top holds the FSM, counters, credit logic and BRAM port muxing.

Test Plan:
- Conv mode, size=2, ch=3 (N=12); pool_last bits pulsed in random cycles across 20 cycles; SA BRAM model holds addr+0x10; ready_i=1.
  - Expected: READ starts the cycle after the mask completes; 12 bytes 0x10..0x1B on consecutive cycles; last_o on 0x1B; done_o the next cycle.
- FC mode, fc_len=10; act_last_i pulsed 5 cycles after start; ready_i=1.
  - Expected: fc_rdptr 0..9; sa_rden_o stays 0; 10 bytes in order; last_o on the 10th byte.
- Back-pressure, conv N=8; ready_i toggles 1,0,0,1 repeating.
  - Expected: no byte lost or duplicated; data stable while stalled; in-flight reads never exceed 2.
- fc_len=0 with act_last_i asserted.
  - Expected: valid_o never asserted; done_o pulses exactly once; back to IDLE.
- Second start_i asserted during READ.
  - Expected: ignored; configuration unchanged; a single done_o.
- rst asserted mid-READ, at element 5 of 12.
  - Expected: next cycle all outputs 0, state IDLE; a new start then produces a clean full stream from address 0.

Source files
------------

// File: rtl/acpo_rb_pkg.sv
// acpo_rb_pkg: shared widths, FIFO depth and FSM state type for the pool readback drain stage
package acpo_rb_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int SA_ADDR_WIDTH = 14;
  localparam int FC_ADDR_WIDTH = 10;
  localparam int LANES = 16;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;
endpackage

// File: rtl/rb_skid_fifo.sv
// rb_skid_fifo: 2-entry skid FIFO holding BRAM returns, head drives the stream
module rb_skid_fifo
  import acpo_rb_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == 2'(FIFO_DEPTH);
  assign empty = count == 2'd0;
endmodule

// File: rtl/pool_readback_ctrl.sv
// pool_readback_ctrl: waits for pool/FC completion, then streams SA or FC BRAM bytes over valid/ready
module pool_readback_ctrl
  import acpo_rb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     mode_fc_i,
  input  logic [3:0]               pool_size_i,
  input  logic [5:0]               ch_i,
  input  logic [FC_ADDR_WIDTH-1:0] fc_len_i,
  input  logic [LANES-1:0]         pool_last_i,
  input  logic                     act_last_i,
  output logic                     sa_rden_o,
  output logic [SA_ADDR_WIDTH-1:0] sa_rdptr_o,
  input  logic [DATA_WIDTH-1:0]    sa_rdata_i,
  output logic                     fc_rden_o,
  output logic [FC_ADDR_WIDTH-1:0] fc_rdptr_o,
  input  logic [DATA_WIDTH-1:0]    fc_rdata_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o
);
  state_t state, state_nx;
  logic mode_fc, inflight, done_r, issue, pop, credit_ok, drain_ok, go;
  logic fifo_full, fifo_empty;
  logic [1:0] fifo_cnt;
  logic [LANES-1:0] mask, mask_nx;
  logic [SA_ADDR_WIDTH-1:0] n, rd_addr, out_cnt;
  logic [2:0] used;
  assign mask_nx = mask | pool_last_i;
  assign go = mode_fc ? act_last_i : &mask_nx;
  assign valid_o = !fifo_empty;
  assign pop = valid_o && ready_i;
  // a slot freed by this cycle's pop can be reused by this cycle's read
  assign used = 3'(fifo_cnt) + 3'(inflight);
  assign credit_ok = used < 3'd2 + 3'(pop);
  assign issue = state == READ && credit_ok && (!fifo_full || pop);
  assign drain_ok = !inflight && (fifo_empty || (fifo_cnt == 2'd1 && pop));
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start_i ? WAIT : IDLE;
      WAIT:  state_nx = go ? (n == '0 ? IDLE : READ) : WAIT;
      READ:  state_nx = (issue && rd_addr == n - 1'b1) ? DRAIN : READ;
      DRAIN: state_nx = drain_ok ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_fc <= 1'b0;
      n <= '0;
      mask <= '0;
      rd_addr <= '0;
      out_cnt <= '0;
      inflight <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= issue;
      done_r <= state != IDLE && state_nx == IDLE;
      if (state == IDLE && start_i) begin
        mode_fc <= mode_fc_i;
        n <= mode_fc_i ? SA_ADDR_WIDTH'(fc_len_i)
                       : SA_ADDR_WIDTH'(pool_size_i) * SA_ADDR_WIDTH'(pool_size_i) * SA_ADDR_WIDTH'(ch_i);
        mask <= '0;
        rd_addr <= '0;
        out_cnt <= '0;
      end
      if (state == WAIT) mask <= mask_nx;
      if (issue) rd_addr <= rd_addr + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
    end
  end
  rb_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .din(mode_fc ? fc_rdata_i : sa_rdata_i),
    .dout(data_o),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
  assign sa_rden_o = issue && !mode_fc;
  assign fc_rden_o = issue && mode_fc;
  assign sa_rdptr_o = sa_rden_o ? rd_addr : '0;
  assign fc_rdptr_o = fc_rden_o ? rd_addr[FC_ADDR_WIDTH-1:0] : '0;
  assign last_o = valid_o && out_cnt == n - 1'b1;
  assign busy_o = state != IDLE;
  assign done_o = done_r;
endmodule
